// File: rtl/diad_pkg.sv
// Shared definitions for the instruction-memory loader.
//   INSTR_W / INSTR_DEPTH : instruction word width and memory depth.
//   ld_state_e            : loader FSM encoding. The bench also uses it to check states.
//   ld_state_accepts      : states in which the loader takes a stream byte.
//   ld_state_busy         : states that count as a load in progress.
package diad_pkg;

  localparam int INSTR_W     = 24;
  localparam int INSTR_DEPTH = 4096;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR_HI = 4'd1,
    ST_HDR_LO = 4'd2,
    ST_B2     = 4'd3,
    ST_B1     = 4'd4,
    ST_B0     = 4'd5,
    ST_WRITE  = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } ld_state_e;

  // The only states that consume a stream byte.
  function automatic logic ld_state_accepts(input ld_state_e st);
    logic acc;
    case (st)
      ST_HDR_HI, ST_HDR_LO, ST_B2, ST_B1, ST_B0: acc = 1'b1;
      default:                                   acc = 1'b0;
    endcase
    return acc;
  endfunction

  // Busy covers everything between start and DONE/ERR, including WRITE.
  function automatic logic ld_state_busy(input ld_state_e st);
    logic bsy;
    case (st)
      ST_HDR_HI, ST_HDR_LO, ST_B2, ST_B1, ST_B0, ST_WRITE: bsy = 1'b1;
      default:                                             bsy = 1'b0;
    endcase
    return bsy;
  endfunction

endpackage

// File: rtl/instr_word_asm.sv
// Big-endian 24-bit word assembler.
// Keeps the two most recently accepted bytes; the assembled word is those two
// bytes followed by the byte being accepted this cycle, so the complete word is
// available in the same cycle as the third byte handshake.
//   clk      : clock
//   rst      : synchronous active-high reset (clears history)
//   clr      : synchronous clear, used at the start of every load
//   load_en  : shift byte_in into the history
//   byte_in  : incoming stream byte
//   word     : {older byte, newer byte, byte_in}
module instr_word_asm
  import diad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word
);

  logic [15:0] hist_r;

  // Byte history shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 16'h0000;
    end else if (clr) begin
      hist_r <= 16'h0000;
    end else if (load_en) begin
      hist_r <= {hist_r[7:0], byte_in};
    end else begin
      hist_r <= hist_r;
    end
  end

  assign word = {hist_r, byte_in};

endmodule

// File: rtl/instr_loader.sv
// Writer side of the instruction memory.
// Receives a byte stream (16-bit big-endian word count, then that many
// big-endian 3-byte words) and issues one sequential write per word. busy is
// high for the whole load and holds the core in reset.
//   clk       : clock
//   rst       : synchronous active-high reset
//   start     : begin a load; honoured only in IDLE, DONE or ERR
//   in_data   : stream byte
//   in_valid  : in_data valid
//   in_ready  : loader takes a byte this cycle (transfer = in_valid & in_ready)
//   mem_we    : single-cycle write strobe
//   mem_addr  : write address (zero-extended word index)
//   mem_wdata : write data
//   busy      : load in progress
//   done      : last load finished OK (level, cleared by start/rst)
//   err       : word count exceeded DEPTH (level, cleared by start/rst)
module instr_loader
  import diad_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ld_state_e           state_r;
  ld_state_e           state_next_s;

  logic                in_ready_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic [7:0]          cnt_hi_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    idx_r;

  logic                xfer_s;
  logic                start_ok_s;
  logic [CNT_W-1:0]    hdr_s;
  logic                hdr_too_big_s;
  logic [CNT_W-1:0]    idx_inc_s;
  logic                last_s;
  logic                asm_load_s;
  logic [DATA_W-1:0]   asm_word_s;

  // in_ready_r mirrors ld_state_accepts(state_r), so xfer_s is a true handshake.
  assign xfer_s        = in_valid & in_ready_r;
  assign start_ok_s    = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
  // Full header as it completes on the HDR_LO transfer.
  assign hdr_s         = {cnt_hi_r, in_data};
  assign hdr_too_big_s = (32'(hdr_s) > 32'(DEPTH));
  assign idx_inc_s     = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s        = (idx_inc_s == cnt_r);
  assign asm_load_s    = xfer_s & ((state_r == ST_B2) | (state_r == ST_B1) | (state_r == ST_B0));

  instr_word_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok_s),
    .load_en (asm_load_s),
    .byte_in (in_data),
    .word    (asm_word_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; byte states advance only on a transfer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next_s = ST_HDR_HI;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_HDR_HI: begin
        if (xfer_s) begin
          state_next_s = ST_HDR_LO;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_HDR_LO: begin
        if (!xfer_s) begin
          state_next_s = state_r;
        end else if (hdr_s == {CNT_W{1'b0}}) begin
          state_next_s = ST_DONE;
        end else if (hdr_too_big_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_B2;
        end
      end
      ST_B2: begin
        if (xfer_s) begin
          state_next_s = ST_B1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_B1: begin
        if (xfer_s) begin
          state_next_s = ST_B0;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_B0: begin
        if (xfer_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_WRITE: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_B2;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      mem_we_r   <= 1'b0;
    end else begin
      in_ready_r <= ld_state_accepts(state_next_s);
      busy_r     <= ld_state_busy(state_next_s);
      done_r     <= (state_next_s == ST_DONE);
      err_r      <= (state_next_s == ST_ERR);
      // The write strobe is high for exactly the one WRITE cycle.
      mem_we_r   <= (state_next_s == ST_WRITE);
    end
  end

  // Header capture and word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi_r <= 8'h00;
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == ST_HDR_HI) && xfer_s) begin
        cnt_hi_r <= in_data;
      end else begin
        cnt_hi_r <= cnt_hi_r;
      end
      if ((state_r == ST_HDR_LO) && xfer_s) begin
        cnt_r <= hdr_s;
      end else begin
        cnt_r <= cnt_r;
      end
      // Index stops at N-1 on the last word, so it never exceeds DEPTH-1.
      if (start_ok_s) begin
        idx_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_WRITE) && !last_s) begin
        idx_r <= idx_inc_s;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Write address/data load on the third byte and hold until the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_B0) && xfer_s) begin
      mem_addr_r  <= ADDR_W'(idx_r);
      mem_wdata_r <= asm_word_s;
    end else begin
      mem_addr_r  <= mem_addr_r;
      mem_wdata_r <= mem_wdata_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
